// File: rtl/bpsk_symbol_slicer_if.sv
// Bit stream from the BPSK slicer to its consumer over a valid/ready handshake.
// soft_data is present only when BPSK_SLICER_SOFT_OUT_EN is defined.
interface bpsk_symbol_slicer_if;
    logic       bit_data;
    logic       bit_valid;
    logic       bit_ready;
`ifdef BPSK_SLICER_SOFT_OUT_EN
    logic [7:0] soft_data;

    modport master (output bit_data, output bit_valid, output soft_data, input bit_ready);
    modport slave  (input bit_data, input bit_valid, input soft_data, output bit_ready);
`else
    modport master (output bit_data, output bit_valid, input bit_ready);
    modport slave  (input bit_data, input bit_valid, output bit_ready);
`endif
endinterface

// File: rtl/bpsk_symbol_slicer.sv
// BPSK symbol slicer: after preamble lock, aligns to the symbol boundary and slices each
// symbol by square-wave correlation. Define BPSK_SLICER_SOFT_OUT_EN for the soft confidence output.
module bpsk_symbol_slicer #(
    parameter int DATA_WIDTH   = 8,
    parameter int WAVELENGTH   = 8,
    parameter int AMPLITUDE    = 128,
    parameter int PAYLOAD_BITS = 16,
    parameter int OFFSET_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   signal,
    input  logic [OFFSET_WIDTH-1:0] lock_offset,
    input  logic                    lock_valid,
    bpsk_symbol_slicer_if.master    bit_if,
    output logic                    frame_done,
    output logic                    overflow,
    output logic                    busy
);

    localparam int K_W        = $clog2(WAVELENGTH);
    localparam int ACC_W      = DATA_WIDTH + 1 + K_W;
    localparam int HALF       = WAVELENGTH / 2;
    localparam int SYM_W      = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int SOFT_SHIFT = (DATA_WIDTH + K_W > 7) ? (DATA_WIDTH + K_W - 7) : 0;

    localparam logic signed [DATA_WIDTH:0] AMP_S    = (DATA_WIDTH + 1)'(AMPLITUDE);
    localparam logic [K_W-1:0]             K_LAST   = K_W'(WAVELENGTH - 1);
    localparam logic [K_W-1:0]             K_HALF   = K_W'(HALF);
    localparam logic [SYM_W-1:0]           SYM_LAST = SYM_W'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        INTEG = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] align_cnt_q, align_cnt_d;
    logic [K_W-1:0]          k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SYM_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic                    bit_data_q, bit_data_d;
    logic                    bit_valid_q, bit_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overflow_q, overflow_d;

    logic signed [DATA_WIDTH:0] sample_s;
    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       decision;
    logic                       dec_bit;
    logic                       accept;

`ifdef BPSK_SLICER_SOFT_OUT_EN
    logic [7:0]       soft_data_q, soft_data_d;
    logic [ACC_W-1:0] acc_abs;
    logic [31:0]      acc_scaled;
    logic [7:0]       soft_val;
`endif

    // Carrier correlation: +1 weight in the first half-period, -1 in the second.
    always_comb begin
        sample_s   = $signed({1'b0, signal}) - AMP_S;
        sample_ext = {{(ACC_W - DATA_WIDTH - 1){sample_s[DATA_WIDTH]}}, sample_s};
        acc_next   = (k_q < K_HALF) ? (acc_q + sample_ext) : (acc_q - sample_ext);
    end

`ifdef BPSK_SLICER_SOFT_OUT_EN
    // Magnitude of the final correlation, scaled down and clamped to 8 bits.
    always_comb begin
        acc_abs    = acc_next[ACC_W-1] ? ACC_W'(-acc_next) : ACC_W'(acc_next);
        acc_scaled = 32'(acc_abs) >> SOFT_SHIFT;
        soft_val   = (acc_scaled > 32'd255) ? 8'd255 : acc_scaled[7:0];
    end
`endif

    always_comb begin
        state_d      = state_q;
        align_cnt_d  = align_cnt_q;
        k_d          = k_q;
        acc_d        = acc_q;
        sym_cnt_d    = sym_cnt_q;
        frame_done_d = 1'b0;
        decision     = 1'b0;
        dec_bit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (lock_valid) begin
                    state_d     = ALIGN;
                    align_cnt_d = lock_offset;
                end
            end
            ALIGN: begin
                if (!lock_valid) begin
                    state_d = IDLE;
                end else if (align_cnt_q == '0) begin
                    state_d   = INTEG;
                    k_d       = '0;
                    acc_d     = '0;
                    sym_cnt_d = '0;
                end else begin
                    align_cnt_d = align_cnt_q - 1'b1;
                end
            end
            INTEG: begin
                // Losing lock discards the partial symbol without a decision.
                if (!lock_valid) begin
                    state_d = IDLE;
                    k_d     = '0;
                    acc_d   = '0;
                end else if (k_q == K_LAST) begin
                    decision  = 1'b1;
                    dec_bit   = ~acc_next[ACC_W-1];
                    acc_d     = '0;
                    k_d       = '0;
                    sym_cnt_d = sym_cnt_q + 1'b1;
                    if (sym_cnt_q == SYM_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                        sym_cnt_d    = '0;
                    end
                end else begin
                    acc_d = acc_next;
                    k_d   = k_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output holding register: a new decision always wins; overflow marks a lost bit.
    always_comb begin
        accept      = bit_valid_q & bit_if.bit_ready;
        bit_data_d  = bit_data_q;
        bit_valid_d = bit_valid_q;
        overflow_d  = overflow_q;
`ifdef BPSK_SLICER_SOFT_OUT_EN
        soft_data_d = soft_data_q;
`endif
        if (accept) begin
            bit_valid_d = 1'b0;
        end
        if (decision) begin
            bit_data_d  = dec_bit;
            bit_valid_d = 1'b1;
`ifdef BPSK_SLICER_SOFT_OUT_EN
            soft_data_d = soft_val;
`endif
            if (bit_valid_q && !bit_if.bit_ready) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            align_cnt_q  <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            sym_cnt_q    <= '0;
            bit_data_q   <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            align_cnt_q  <= align_cnt_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            sym_cnt_q    <= sym_cnt_d;
            bit_data_q   <= bit_data_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef BPSK_SLICER_SOFT_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soft_data_q <= '0;
        end else begin
            soft_data_q <= soft_data_d;
        end
    end

    assign bit_if.soft_data = soft_data_q;
`endif

    assign bit_if.bit_data  = bit_data_q;
    assign bit_if.bit_valid = bit_valid_q;
    assign frame_done       = frame_done_q;
    assign overflow         = overflow_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_bpsk_symbol_slicer.sv
// Scoreboard bench for bpsk_symbol_slicer: a correlation model pushes expected bits as
// samples are driven; a negedge monitor pops them when the consumer accepts a bit.
module tb_bpsk_symbol_slicer;

    localparam int W    = 8;
    localparam int HALF = W / 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] signal;
    logic [6:0] lock_offset;
    logic       lock_valid;
    logic       frame_done;
    logic       overflow;
    logic       busy;

    bpsk_symbol_slicer_if bit_if ();

    bpsk_symbol_slicer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (signal),
        .lock_offset (lock_offset),
        .lock_valid  (lock_valid),
        .bit_if      (bit_if),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
`ifdef BPSK_SLICER_SOFT_OUT_EN
    logic [7:0] soft_q[$];
`endif
    int   model_acc = 0;
    int   model_k   = 0;
    int   bits_seen = 0;
    int   fd_count  = 0;
    int   fd_at_bit = 0;
    bit   mon_en    = 1'b1;
    logic [7:0] sine_tab [8] = '{8'd128, 8'd199, 8'd228, 8'd199, 8'd128, 8'd57, 8'd28, 8'd57};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: each negedge with valid&&ready is one bit the consumer takes at the next edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bit_if.bit_valid && bit_if.bit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_bit: got bit_data=%0b, required no bit pending", bit_if.bit_data);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    checks++;
                    if (bit_if.bit_data !== e) begin
                        errors++;
                        $display("[TB] FAIL bit_data[%0d]: got %0b, required %0b", bits_seen, bit_if.bit_data, e);
                    end
`ifdef BPSK_SLICER_SOFT_OUT_EN
                    begin
                        logic [7:0] es;
                        es = soft_q.pop_front();
                        checks++;
                        if (bit_if.soft_data !== es) begin
                            errors++;
                            $display("[TB] FAIL soft_data[%0d]: got %0d, required %0d", bits_seen, bit_if.soft_data, es);
                        end
                    end
`endif
                end
                bits_seen++;
            end
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_at_bit = bits_seen;
            end
        end
    end

    task automatic model_clear();
        model_acc = 0;
        model_k   = 0;
        exp_q.delete();
`ifdef BPSK_SLICER_SOFT_OUT_EN
        soft_q.delete();
`endif
    endtask

    task automatic start_lock(input int offset);
        @(negedge clk);
        model_acc   = 0;
        model_k     = 0;
        lock_offset = 7'(offset);
        lock_valid  = 1'b1;
        repeat (offset + 1) @(negedge clk);
    endtask

    task automatic drive_sample(input logic [7:0] v);
        int s;
        int a;
        @(negedge clk);
        signal = v;
        s = int'(v) - 128;
        model_acc += (model_k < HALF) ? s : -s;
        if (model_k == W - 1) begin
            exp_q.push_back(model_acc >= 0);
            a = (model_acc < 0) ? -model_acc : model_acc;
            a = a >> 4;
            if (a > 255) a = 255;
`ifdef BPSK_SLICER_SOFT_OUT_EN
            soft_q.push_back(8'(a));
`endif
            model_acc = 0;
            model_k   = 0;
        end else begin
            model_k++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        signal      = 8'd128;
        lock_offset = '0;
        lock_valid  = 1'b0;
        bit_if.bit_ready = 1'b1;
        #12;
        checks++;
        if (bit_if.bit_valid !== 1'b0 || bit_if.bit_data !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bit: got valid=%0b data=%0b, required 0 0", bit_if.bit_valid, bit_if.bit_data);
        end
        checks++;
        if (frame_done !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got fd=%0b ovf=%0b busy=%0b, required 0 0 0", frame_done, overflow, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_frame();
        int b0;
        int f0;
        b0 = bits_seen;
        f0 = fd_count;
        start_lock(3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_align: got %0b, required 1", busy);
        end
        for (int sym = 0; sym < 16; sym++) begin
            for (int n = 0; n < W; n++) begin
                drive_sample((sym % 2 == 0) ? sine_tab[n] : 8'(256 - int'(sine_tab[n])));
            end
        end
        @(negedge clk);
        lock_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fd_count - f0 !== 1) begin
            errors++;
            $display("[TB] FAIL frame_done_count: got %0d pulses, required 1", fd_count - f0);
        end
        checks++;
        if (fd_at_bit - b0 !== 16) begin
            errors++;
            $display("[TB] FAIL frame_done_align: got pulse at bit %0d, required 16", fd_at_bit - b0);
        end
        checks++;
        if (bits_seen - b0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL frame_bits: got %0d bits, %0d pending, required 16 0", bits_seen - b0, exp_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_end_frame: got %0b, required 0", busy);
        end
    endtask

    task automatic test_dc();
        int b0;
        b0 = bits_seen;
        start_lock(0);
        for (int n = 0; n < W; n++) drive_sample(8'd128);
        @(negedge clk);
        lock_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bits_seen - b0 !== 1 || exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL dc_bit_count: got %0d bits, required 1", bits_seen - b0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dc_abort_idle: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_abort();
        int b0;
        int f0;
        b0 = bits_seen;
        f0 = fd_count;
        start_lock(2);
        for (int sym = 0; sym < 3; sym++) begin
            for (int n = 0; n < W; n++) begin
                drive_sample((sym % 2 == 0) ? 8'(256 - int'(sine_tab[n])) : sine_tab[n]);
            end
        end
        for (int n = 0; n < 4; n++) drive_sample(sine_tab[n]);
        @(negedge clk);
        lock_valid = 1'b0;
        signal     = 8'd228;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%0b, required 0", busy);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (bits_seen - b0 !== 3) begin
            errors++;
            $display("[TB] FAIL abort_bits: got %0d bits, required 3", bits_seen - b0);
        end
        checks++;
        if (fd_count !== f0) begin
            errors++;
            $display("[TB] FAIL abort_frame_done: got %0d pulses, required 0", fd_count - f0);
        end
        model_clear();
    endtask

    task automatic test_overflow();
        mon_en = 1'b0;
        bit_if.bit_ready = 1'b0;
        start_lock(1);
        for (int n = 0; n < W; n++) drive_sample(sine_tab[n]);
        for (int n = 0; n < W; n++) begin
            drive_sample(8'(256 - int'(sine_tab[n])));
            if (n == 0) begin
                checks++;
                if (bit_if.bit_valid !== 1'b1 || bit_if.bit_data !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL first_held_bit: got valid=%0b data=%0b ovf=%0b, required 1 1 0",
                             bit_if.bit_valid, bit_if.bit_data, overflow);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bit_if.bit_valid !== 1'b1 || bit_if.bit_data !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overwrite_bit: got valid=%0b data=%0b, required 1 0", bit_if.bit_valid, bit_if.bit_data);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_set: got %0b, required 1", overflow);
        end
        bit_if.bit_ready = 1'b1;
        lock_valid       = 1'b0;
        @(negedge clk);
        checks++;
        if (bit_if.bit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_accept: got valid=%0b busy=%0b, required 0 0", bit_if.bit_valid, busy);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: got %0b, required 1", overflow);
        end
        model_clear();
        mon_en = 1'b1;
    endtask

`ifdef BPSK_SLICER_SOFT_OUT_EN
    task automatic test_soft();
        int b0;
        b0 = bits_seen;
        start_lock(0);
        for (int n = 0; n < W; n++) drive_sample((n < HALF) ? 8'd255 : 8'd0);
        for (int n = 0; n < W; n++) drive_sample(8'd128);
        @(negedge clk);
        lock_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bits_seen - b0 !== 2 || soft_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL soft_bits: got %0d bits, required 2", bits_seen - b0);
        end
    endtask
`endif

    task automatic test_reset_mid_integ();
        start_lock(2);
        for (int n = 0; n < 6; n++) drive_sample(sine_tab[n]);
        #1;
        rst_n      = 1'b0;
        lock_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bit_if.bit_valid !== 1'b0 || bit_if.bit_data !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_out: got busy=%0b valid=%0b data=%0b, required 0 0 0",
                     busy, bit_if.bit_valid, bit_if.bit_data);
        end
        checks++;
        if (overflow !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_flags: got ovf=%0b fd=%0b, required 0 0", overflow, frame_done);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bit_if.bit_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got busy=%0b valid=%0b, required 0 0", busy, bit_if.bit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_dc();
        test_abort();
`ifdef BPSK_SLICER_SOFT_OUT_EN
        test_soft();
`endif
        test_overflow();
        test_reset_mid_integ();
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
